mem_burst_master: RTL and testbench

Upstream requester for the 16-bit word memory slave. It accepts one burst command (start byte address, word count, direction) and issues sequential word accesses over the slave's four-phase REQ/ACK handshake.
- Write data comes from a valid/ready input stream.
- Read data is returned as a valid pulse stream.
- Each access has a watchdog timeout.

---
 rtl/mem_bus_pkg.sv | 21 ++
 rtl/mem_hs_timeout.sv | 33 +++
 rtl/mem_burst_master.sv | 142 ++++++++++++++
 tb/tb_mem_burst_master.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
`default_nettype none
// ============================================================================
//  mem_bus_pkg
//  Shared types and constants for the 16-bit word memory bus master.
//  Revision: 1.0
// ============================================================================
package mem_bus_pkg;

    localparam int          WORD_W    = 16;
    localparam logic [15:0] ADDR_STEP = 16'd2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_REQ   = 3'd2,
        ST_REL   = 3'd3,
        ST_FIN   = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mem_hs_timeout.sv
`default_nettype none
// ============================================================================
//  mem_hs_timeout
//  Handshake-phase watchdog: counts enabled cycles, saturates at TIMEOUT.
//  Revision: 1.0
// ============================================================================
module mem_hs_timeout #(
    parameter int TO_W    = 8,
    parameter int TIMEOUT = 200
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [TO_W-1:0] LIMIT = TO_W'(TIMEOUT);

    logic [TO_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable && (count != LIMIT)) begin
            count <= count + TO_W'(1);
        end
    end

    assign expired = (count == LIMIT);

endmodule
`default_nettype wire

// File: rtl/mem_burst_master.sv
`default_nettype none
// ============================================================================
//  mem_burst_master
//  Burst requester issuing sequential word accesses over a REQ/ACK handshake.
//  Revision: 1.0
// ============================================================================
module mem_burst_master
    import mem_bus_pkg::*;
#(
    parameter int LEN_W   = 8,
    parameter int TO_W    = 8,
    parameter int TIMEOUT = 200
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              CMD_VALID,
    output logic              CMD_READY,
    input  logic [WORD_W-1:0] CMD_ADDR,
    input  logic [LEN_W-1:0]  CMD_LEN,
    input  logic              CMD_WEN,
    input  logic [WORD_W-1:0] WR_DATA,
    input  logic              WR_VALID,
    output logic              WR_READY,
    output logic [WORD_W-1:0] RD_DATA,
    output logic              RD_VALID,
    output logic [WORD_W-1:0] M_ADDR,
    output logic [WORD_W-1:0] M_WDATA,
    input  logic [WORD_W-1:0] M_RDATA,
    output logic              M_REQ,
    output logic              M_WEN,
    input  logic              M_ACK,
    output logic              BUSY,
    output logic              DONE,
    output logic              ERR
);

    state_t              state;
    logic [WORD_W-1:0]   addr;
    logic [LEN_W-1:0]    remaining;
    logic                wen;
    logic                fetch_go;
    logic                to_clear;
    logic                to_en;
    logic                to_expired;

    assign CMD_READY = (state == ST_IDLE);
    assign WR_READY  = (state == ST_FETCH) && wen;
    assign fetch_go  = (state == ST_FETCH) && (!wen || WR_VALID);

    // Watchdog restarts on entry to each handshake phase
    assign to_clear = fetch_go || ((state == ST_REQ) && M_ACK);
    assign to_en    = (state == ST_REQ) || (state == ST_REL);

    mem_hs_timeout #(
        .TO_W    (TO_W),
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (CLK),
        .rst     (RST),
        .clear   (to_clear),
        .enable  (to_en),
        .expired (to_expired)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= ST_IDLE;
            addr      <= '0;
            remaining <= '0;
            wen       <= 1'b0;
            RD_DATA   <= '0;
            RD_VALID  <= 1'b0;
            M_ADDR    <= '0;
            M_WDATA   <= '0;
            M_REQ     <= 1'b0;
            M_WEN     <= 1'b0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            ERR       <= 1'b0;
        end else begin
            DONE     <= 1'b0;
            RD_VALID <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (CMD_VALID) begin
                        addr      <= CMD_ADDR;
                        remaining <= CMD_LEN;
                        wen       <= CMD_WEN;
                        ERR       <= 1'b0;
                        BUSY      <= 1'b1;
                        state     <= (CMD_LEN == '0) ? ST_FIN : ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (fetch_go) begin
                        M_ADDR <= addr;
                        M_REQ  <= 1'b1;
                        M_WEN  <= wen;
                        if (wen) begin
                            M_WDATA <= WR_DATA;
                        end
                        state <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (M_ACK) begin
                        M_REQ <= 1'b0;
                        M_WEN <= 1'b0;
                        if (!wen) begin
                            RD_DATA  <= M_RDATA;
                            RD_VALID <= 1'b1;
                        end
                        state <= ST_REL;
                    end else if (to_expired) begin
                        M_REQ <= 1'b0;
                        M_WEN <= 1'b0;
                        ERR   <= 1'b1;
                        state <= ST_FIN;
                    end
                end
                ST_REL: begin
                    if (!M_ACK) begin
                        addr      <= addr + ADDR_STEP;
                        remaining <= remaining - LEN_W'(1);
                        state     <= (remaining == LEN_W'(1)) ? ST_FIN : ST_FETCH;
                    end else if (to_expired) begin
                        ERR   <= 1'b1;
                        state <= ST_FIN;
                    end
                end
                ST_FIN: begin
                    DONE  <= 1'b1;
                    BUSY  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_burst_master.sv
`default_nettype none
// ============================================================================
//  tb_mem_burst_master
//  Self-checking bench: slave model, table vectors, corner cases, random bursts.
//  Revision: 1.0
// ============================================================================
module tb_mem_burst_master;

    localparam int LEN_W   = 8;
    localparam int TO_W    = 8;
    localparam int TIMEOUT = 20;

    logic              CLK = 1'b0;
    logic              RST;
    logic              CMD_VALID, CMD_READY, CMD_WEN;
    logic [15:0]       CMD_ADDR;
    logic [LEN_W-1:0]  CMD_LEN;
    logic [15:0]       WR_DATA, RD_DATA, M_ADDR, M_WDATA, M_RDATA;
    logic              WR_VALID, WR_READY, RD_VALID, M_REQ, M_WEN, M_ACK;
    logic              BUSY, DONE, ERR;

    always #5 CLK = ~CLK;

    mem_burst_master #(.LEN_W(LEN_W), .TO_W(TO_W), .TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK), .RST(RST), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
        .CMD_ADDR(CMD_ADDR), .CMD_LEN(CMD_LEN), .CMD_WEN(CMD_WEN),
        .WR_DATA(WR_DATA), .WR_VALID(WR_VALID), .WR_READY(WR_READY),
        .RD_DATA(RD_DATA), .RD_VALID(RD_VALID), .M_ADDR(M_ADDR),
        .M_WDATA(M_WDATA), .M_RDATA(M_RDATA), .M_REQ(M_REQ), .M_WEN(M_WEN),
        .M_ACK(M_ACK), .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- slave model and observers ----------------
    typedef struct packed { logic [15:0] a; logic w; logic [15:0] d; } acc_t;

    logic [15:0] smem [logic [15:0]];
    acc_t        acc_q[$];
    logic [15:0] rd_q[$];
    bit          ack_en = 1'b1;
    bit          stuck  = 1'b0;
    int          sdly   = 0;
    int          dn_cnt, req_hi, fetch_viol, fetch_cyc;

    initial begin
        M_ACK   = 1'b0;
        M_RDATA = 16'h0;
        forever begin
            @(negedge CLK);
            if (M_REQ && !M_ACK && ack_en) begin
                if (sdly > 0) sdly--;
                else begin
                    if (M_WEN) begin
                        smem[M_ADDR] = M_WDATA;
                        acc_q.push_back({M_ADDR, 1'b1, M_WDATA});
                    end else begin
                        M_RDATA = smem.exists(M_ADDR) ? smem[M_ADDR] : 16'h0;
                        acc_q.push_back({M_ADDR, 1'b0, 16'h0});
                    end
                    M_ACK = 1'b1;
                    sdly  = $urandom_range(0, 2);
                end
            end else if (!M_REQ && M_ACK && !stuck) begin
                if (sdly > 0) sdly--;
                else begin
                    M_ACK = 1'b0;
                    sdly  = $urandom_range(0, 2);
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge CLK);
            if (RD_VALID) rd_q.push_back(RD_DATA);
            if (DONE) dn_cnt++;
            if (M_REQ) req_hi++;
            if (WR_READY && M_REQ) fetch_viol++;
            if (WR_READY) fetch_cyc++;
        end
    end

    // ---------------- write-data producer ----------------
    logic [15:0] wq[$];
    int          sq[$];
    int          stall_left = 0;

    initial begin
        WR_VALID = 1'b0;
        WR_DATA  = 16'h0;
        forever begin
            @(negedge CLK);
            if (wq.size() > 0) begin
                if (stall_left > 0) begin
                    stall_left--;
                    WR_VALID = 1'b0;
                end else begin
                    WR_VALID = 1'b1;
                    WR_DATA  = wq[0];
                    if (WR_READY) begin
                        void'(wq.pop_front());
                        stall_left = (sq.size() > 0) ? sq.pop_front() : 0;
                    end
                end
            end else begin
                WR_VALID = 1'b0;
            end
        end
    end

    // ---------------- reference model and command helpers ----------------
    logic [15:0] model_mem [logic [15:0]];
    int          extra_acc;
    int          lat;

    task automatic clear_mon();
        acc_q.delete(); rd_q.delete();
        dn_cnt = 0; req_hi = 0; fetch_viol = 0; fetch_cyc = 0; extra_acc = 0;
    endtask

    task automatic issue(input bit wen, input logic [15:0] addr, input int len, input bit hold);
        int n = 0;
        while (!CMD_READY && n < 50) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 50) chk("cmd_ready_wait", 64'(CMD_READY), 64'(1));
        CMD_ADDR  = addr;
        CMD_LEN   = LEN_W'(len);
        CMD_WEN   = wen;
        CMD_VALID = 1'b1;
        @(negedge CLK);
        chk("accept_busy_err", 64'({BUSY, ERR}), 64'(2'b10));
        if (hold) CMD_ADDR = ~addr;
        else      CMD_VALID = 1'b0;
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        lat = 0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            @(negedge CLK);
            lat++;
            if (DONE) seen = 1'b1;
            else if (CMD_VALID && CMD_READY) extra_acc++;
        end
        CMD_VALID = 1'b0;
        if (!seen) chk("done_timeout", 64'(0), 64'(1));
        repeat (3) @(negedge CLK);
    endtask

    task automatic run_cmd(input bit wen, input logic [15:0] addr, input int len,
                           input logic [15:0] base, input int stall0, input int stall1,
                           input bit rnd_stall, input bit hold);
        acc_t        exp_acc[$];
        logic [15:0] exp_rd[$];
        clear_mon();
        for (int i = 0; i < len; i++) begin
            logic [15:0] a;
            a = addr + 16'(2 * i);
            if (wen) begin
                model_mem[a] = base + 16'(i);
                exp_acc.push_back({a, 1'b1, base + 16'(i)});
                wq.push_back(base + 16'(i));
                if (i > 0) sq.push_back((i == 1) ? stall1 : (rnd_stall ? int'($urandom_range(0, 3)) : 0));
            end else begin
                exp_acc.push_back({a, 1'b0, 16'h0});
                exp_rd.push_back(model_mem.exists(a) ? model_mem[a] : 16'h0);
            end
        end
        stall_left = stall0;
        issue(wen, addr, len, hold);
        wait_done();
        chk("acc_count", 64'(acc_q.size()), 64'(exp_acc.size()));
        for (int i = 0; i < exp_acc.size() && i < acc_q.size(); i++)
            chk("access", 64'(acc_q[i]), 64'(exp_acc[i]));
        chk("rd_count", 64'(rd_q.size()), 64'(exp_rd.size()));
        for (int i = 0; i < exp_rd.size() && i < rd_q.size(); i++)
            chk("rd_data", 64'(rd_q[i]), 64'(exp_rd[i]));
        chk("done_pulses", 64'(dn_cnt), 64'(1));
        chk("err_clean", 64'(ERR), 64'(0));
        chk("busy_end", 64'(BUSY), 64'(0));
        chk("req_in_fetch", 64'(fetch_viol), 64'(0));
        if (hold) chk("extra_accept", 64'(extra_acc), 64'(0));
        if (len == 0) begin
            chk("len0_latency", 64'(lat), 64'(1));
            chk("len0_no_req", 64'(req_hi), 64'(0));
        end
        wq.delete(); sq.delete(); stall_left = 0;
    endtask

    typedef struct {
        bit          wen;
        logic [15:0] addr;
        int          len;
        logic [15:0] base;
        int          stall1;
        bit          hold;
        logic [15:0] exp_last;
        logic [15:0] exp_rd0;
    } vec_t;

    vec_t vt[8];

    localparam logic [7:0] RST_FLAGS = 8'b1000_0000;

    initial begin
        vt[0] = '{1'b1, 16'h0010, 3, 16'hA001, 0, 1'b0, 16'h0014, 16'h0000};
        vt[1] = '{1'b0, 16'h0010, 3, 16'h0000, 0, 1'b0, 16'h0014, 16'hA001};
        vt[2] = '{1'b1, 16'hFFFE, 2, 16'hB001, 0, 1'b0, 16'h0000, 16'h0000};
        vt[3] = '{1'b0, 16'hFFFE, 2, 16'h0000, 0, 1'b0, 16'h0000, 16'hB001};
        vt[4] = '{1'b1, 16'h0100, 0, 16'h1111, 0, 1'b0, 16'h0000, 16'h0000};
        vt[5] = '{1'b0, 16'h0200, 0, 16'h0000, 0, 1'b0, 16'h0000, 16'h0000};
        vt[6] = '{1'b1, 16'h0300, 3, 16'hC001, 9, 1'b1, 16'h0304, 16'h0000};
        vt[7] = '{1'b0, 16'h0300, 3, 16'h0000, 0, 1'b0, 16'h0304, 16'hC001};

        RST = 1'b1; CMD_VALID = 1'b0; CMD_ADDR = 16'h0; CMD_LEN = '0; CMD_WEN = 1'b0;
        repeat (3) @(negedge CLK);
        chk("reset_flags", 64'({CMD_READY, WR_READY, RD_VALID, M_REQ, M_WEN, BUSY, DONE, ERR}), 64'(RST_FLAGS));
        chk("reset_data", 64'({RD_DATA, M_ADDR, M_WDATA}), 64'(0));
        RST = 1'b0;
        @(negedge CLK);

        for (int v = 0; v < 8; v++) begin
            run_cmd(vt[v].wen, vt[v].addr, vt[v].len, vt[v].base, 0, vt[v].stall1, 1'b0, vt[v].hold);
            if (vt[v].len > 0)
                chk("last_addr", (acc_q.size() > 0) ? 64'(acc_q[acc_q.size()-1].a) : 64'hFFFF_FFFF,
                    64'(vt[v].exp_last));
            if (!vt[v].wen && vt[v].len > 0)
                chk("first_rd", (rd_q.size() > 0) ? 64'(rd_q[0]) : 64'hFFFF_FFFF, 64'(vt[v].exp_rd0));
            if (vt[v].stall1 > 0)
                chk("fetch_held", 64'(fetch_cyc >= 5), 64'(1));
        end

        // Slave never acknowledges: watchdog aborts in the request phase
        ack_en = 1'b0;
        clear_mon();
        issue(1'b0, 16'h0010, 2, 1'b0);
        wait_done();
        chk("to_req_err", 64'(ERR), 64'(1));
        chk("to_req_done", 64'(dn_cnt), 64'(1));
        chk("to_req_mreq", 64'(M_REQ), 64'(0));
        chk("to_req_no_rd", 64'(rd_q.size()), 64'(0));
        chk("to_req_window", 64'((req_hi >= TIMEOUT) && (req_hi <= TIMEOUT + 2)), 64'(1));
        ack_en = 1'b1;

        // Slave never releases ACK: watchdog aborts in the release phase
        stuck = 1'b1;
        clear_mon();
        wq.push_back(16'hD001); wq.push_back(16'hD002);
        model_mem[16'h0400] = 16'hD001;
        issue(1'b1, 16'h0400, 2, 1'b0);
        wait_done();
        chk("to_rel_err", 64'(ERR), 64'(1));
        chk("to_rel_done", 64'(dn_cnt), 64'(1));
        chk("to_rel_acc", 64'(acc_q.size()), 64'(1));
        if (acc_q.size() > 0) chk("to_rel_first", 64'(acc_q[0]), 64'({16'h0400, 1'b1, 16'hD001}));
        stuck = 1'b0;
        wq.delete(); sq.delete(); stall_left = 0;
        repeat (6) @(negedge CLK);

        // Reset while a request is outstanding
        ack_en = 1'b0;
        clear_mon();
        issue(1'b0, 16'h0500, 1, 1'b0);
        for (int i = 0; i < 20 && !M_REQ; i++) @(negedge CLK);
        chk("rst_mid_req_seen", 64'(M_REQ), 64'(1));
        RST = 1'b1;
        @(negedge CLK);
        chk("rst_mid_flags", 64'({CMD_READY, WR_READY, RD_VALID, M_REQ, M_WEN, BUSY, DONE, ERR}), 64'(RST_FLAGS));
        chk("rst_mid_data", 64'({RD_DATA, M_ADDR, M_WDATA}), 64'(0));
        RST = 1'b0;
        ack_en = 1'b1;
        repeat (2) @(negedge CLK);

        // Random bursts around the top of the address space
        for (int r = 0; r < 25; r++) begin
            bit          w;
            logic [15:0] a;
            w = 1'($urandom_range(0, 1));
            a = 16'hFFF0 + 16'($urandom_range(0, 15)) * 16'd2;
            run_cmd(w, a, int'($urandom_range(0, 6)), 16'($urandom),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b1, 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
